// File: rtl/fila_entrada.sv
// fila_entrada: debounced push-button capture into a first-word-fall-through FIFO.
// Latency: press -> push after 2 sync + DEBOUNCE_CICLOS filter cycles; pushed word visible next cycle.
// Backpressure: a push into a full FIFO without a same-cycle pop is dropped and flags descartado (sticky).
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   botaoEntrada          raw active-low push button (asynchronous)
//   dadosExternos[17:0]   switch word captured on an accepted press
//   leitura               read strobe, pops the head entry when not empty
//   dado_saida[31:0]      head entry, extended to 32 bits (0 when empty)
//   vazia / cheia         FIFO empty / full
//   ocupacao[6:0]         entry count, 0..PROFUNDIDADE
//   ledentrada            debounced button held (state PRESSIONADO)
//   descartado            sticky drop flag, cleared only by reset
//
// Build option: define FILA_ENTRADA_SINAL_EN to sign-extend stored bit 17
// into dado_saida[31:18]; otherwise the upper bits are zero.

module fila_entrada #(
  parameter int PROFUNDIDADE    = 8,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        botaoEntrada,
  input  logic [17:0] dadosExternos,
  input  logic        leitura,
  output logic [31:0] dado_saida,
  output logic        vazia,
  output logic        cheia,
  output logic [6:0]  ocupacao,
  output logic        ledentrada,
  output logic        descartado
);

  localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam int CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [6:0]    OCUP_MAX = 7'(PROFUNDIDADE);

  typedef enum logic [1:0] {
    SOLTO          = 2'd0,
    FILTRA_APERTO  = 2'd1,
    PRESSIONADO    = 2'd2,
    FILTRA_SOLTURA = 2'd3
  } estado_t;

  // ------------------------------------------------------------------
  // Two-flop synchronizer; idles high because the button is active-low.
  // ------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       btn_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], botaoEntrada};
    end
  end

  assign btn_s = sync_q[1];

  // ------------------------------------------------------------------
  // Debounce FSM
  // ------------------------------------------------------------------
  estado_t       estado_q;
  logic [CW-1:0] cnt_q;
  logic          led_q;
  logic          push_req;

  // The push request is the single cycle where the press filter completes,
  // so a long hold can never produce a second push.
  assign push_req = (estado_q == FILTRA_APERTO) && !btn_s && (cnt_q == CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= SOLTO;
      cnt_q    <= '0;
      led_q    <= 1'b0;
    end else begin
      case (estado_q)
        SOLTO: begin
          cnt_q <= '0;
          if (!btn_s) begin
            estado_q <= FILTRA_APERTO;
          end
        end
        FILTRA_APERTO: begin
          if (btn_s) begin
            estado_q <= SOLTO;
            cnt_q    <= '0;
          end else if (cnt_q == CNT_MAX) begin
            estado_q <= PRESSIONADO;
            cnt_q    <= '0;
            led_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSIONADO: begin
          cnt_q <= '0;
          if (btn_s) begin
            estado_q <= FILTRA_SOLTURA;
            led_q    <= 1'b0;
          end
        end
        FILTRA_SOLTURA: begin
          if (!btn_s) begin
            estado_q <= PRESSIONADO;
            cnt_q    <= '0;
            led_q    <= 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            estado_q <= SOLTO;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          estado_q <= SOLTO;
          cnt_q    <= '0;
          led_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ledentrada = led_q;

  // ------------------------------------------------------------------
  // FIFO
  // ------------------------------------------------------------------
  logic [17:0]   mem_q [PROFUNDIDADE];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [6:0]    ocup_q, ocup_d;
  logic          vazia_q, vazia_d;
  logic          cheia_q, cheia_d;
  logic          desc_q, desc_d;
  logic          pop, push;

  // Reads on an empty FIFO are ignored; a full FIFO still accepts a push
  // when the head is being popped in the same cycle.
  assign pop  = leitura && !vazia_q;
  assign push = push_req && (!cheia_q || pop);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    ocup_d = ocup_q;
    desc_d = desc_q;
    if (push) begin
      wr_d = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   ocup_d = ocup_q + 7'd1;
      2'b01:   ocup_d = ocup_q - 7'd1;
      default: ocup_d = ocup_q;
    endcase
    if (push_req && cheia_q && !pop) begin
      desc_d = 1'b1;
    end
    vazia_d = (ocup_d == 7'd0);
    cheia_d = (ocup_d == OCUP_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      ocup_q  <= 7'd0;
      vazia_q <= 1'b1;
      cheia_q <= 1'b0;
      desc_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ocup_q  <= ocup_d;
      vazia_q <= vazia_d;
      cheia_q <= cheia_d;
      desc_q  <= desc_d;
    end
  end

  // Storage is not cleared by reset; the pointers are what define validity.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_q] <= dadosExternos;
    end
  end

  logic [17:0] cabeca;
  logic [13:0] ext;

  assign cabeca = mem_q[rd_q];
`ifdef FILA_ENTRADA_SINAL_EN
  assign ext = {14{cabeca[17]}};
`else
  assign ext = 14'd0;
`endif

  assign dado_saida = vazia_q ? 32'd0 : {ext, cabeca};
  assign vazia      = vazia_q;
  assign cheia      = cheia_q;
  assign ocupacao   = ocup_q;
  assign descartado = desc_q;

endmodule

// File: tb/tb_fila_entrada.sv
// Testbench for fila_entrada (PROFUNDIDADE=4, DEBOUNCE_CICLOS=4).
// Expected pop values go into a scoreboard queue when a press is issued;
// a negedge monitor pops and compares whenever a read hits a non-empty FIFO.

module tb_fila_entrada;

  logic        clock = 1'b0;
  logic        reset;
  logic        botaoEntrada;
  logic [17:0] dadosExternos;
  logic        leitura;
  logic [31:0] dado_saida;
  logic        vazia;
  logic        cheia;
  logic [6:0]  ocupacao;
  logic        ledentrada;
  logic        descartado;

  int n_chk  = 0;
  int n_fail = 0;
  logic [17:0] exp_q[$];
  bit led_seen;

  always #5 clock = ~clock;

  fila_entrada #(
    .PROFUNDIDADE   (4),
    .DEBOUNCE_CICLOS(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .botaoEntrada (botaoEntrada),
    .dadosExternos(dadosExternos),
    .leitura      (leitura),
    .dado_saida   (dado_saida),
    .vazia        (vazia),
    .cheia        (cheia),
    .ocupacao     (ocupacao),
    .ledentrada   (ledentrada),
    .descartado   (descartado)
  );

  function automatic logic [31:0] ext(input logic [17:0] v);
`ifdef FILA_ENTRADA_SINAL_EN
    return {{14{v[17]}}, v};
`else
    return {14'd0, v};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare the head against the scoreboard on every effective pop.
  always @(negedge clock) begin
    if (ledentrada) led_seen = 1'b1;
    if (!reset && leitura && !vazia) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got %h expected no data", dado_saida);
      end else begin
        check("pop_data", dado_saida, ext(exp_q.pop_front()));
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic press(input logic [17:0] v, input bit accepted);
    if (accepted) exp_q.push_back(v);
    dadosExternos = v;
    botaoEntrada  = 1'b0;
    step(12);
    botaoEntrada  = 1'b1;
    step(12);
  endtask

  task automatic ler();
    leitura = 1'b1;
    step(1);
    leitura = 1'b0;
    step(1);
  endtask

  initial begin
    reset         = 1'b1;
    botaoEntrada  = 1'b1;
    dadosExternos = 18'd0;
    leitura       = 1'b0;
    step(3);
    reset = 1'b0;

    // Reset state
    check("rst_vazia", 32'(vazia), 32'd1);
    check("rst_cheia", 32'(cheia), 32'd0);
    check("rst_ocupacao", 32'(ocupacao), 32'd0);
    check("rst_dado", dado_saida, 32'd0);
    check("rst_led", 32'(ledentrada), 32'd0);
    check("rst_desc", 32'(descartado), 32'd0);

    // Read on empty FIFO is ignored
    ler();
    check("empty_read_ocup", 32'(ocupacao), 32'd0);
    check("empty_read_vazia", 32'(vazia), 32'd1);

    // Single press held 20 cycles: data visible 2+4+1 cycles after press
    exp_q.push_back(18'h00005);
    dadosExternos = 18'h00005;
    botaoEntrada  = 1'b0;
    step(7);
    check("press_dado", dado_saida, 32'h5);
    check("press_ocup", 32'(ocupacao), 32'd1);
    check("press_led", 32'(ledentrada), 32'd1);
    step(13);
    botaoEntrada = 1'b1;
    step(12);
    check("hold_one_push", 32'(ocupacao), 32'd1);
    check("release_led", 32'(ledentrada), 32'd0);
    ler();
    check("after_pop_vazia", 32'(vazia), 32'd1);
    check("after_pop_dado", dado_saida, 32'd0);

    // Bounce: 0,0,1 repeated 5 times -> never accepted
    led_seen = 1'b0;
    dadosExternos = 18'h0003F;
    for (int i = 0; i < 5; i++) begin
      botaoEntrada = 1'b0;
      step(2);
      botaoEntrada = 1'b1;
      step(1);
    end
    step(12);
    check("bounce_ocup", 32'(ocupacao), 32'd0);
    check("bounce_led", 32'(led_seen), 32'd0);

    // Five presses, no reads: fifth dropped
    for (int i = 1; i <= 5; i++) press(18'(i), i <= 4);
    check("full_ocup", 32'(ocupacao), 32'd4);
    check("full_cheia", 32'(cheia), 32'd1);
    check("full_desc", 32'(descartado), 32'd1);
    check("full_head", dado_saida, 32'h1);
    for (int i = 0; i < 4; i++) ler();
    check("drain_vazia", 32'(vazia), 32'd1);
    check("drain_dado", dado_saida, 32'd0);
    check("desc_sticky", 32'(descartado), 32'd1);

    // Full FIFO, press accepted in the same cycle as a read
    do_reset();
    check("reset_desc", 32'(descartado), 32'd0);
    for (int i = 6; i <= 9; i++) press(18'(i), 1'b1);
    check("full2_ocup", 32'(ocupacao), 32'd4);
    exp_q.push_back(18'd10);
    dadosExternos = 18'd10;
    botaoEntrada  = 1'b0;
    step(6);
    leitura = 1'b1;       // high during the push-request cycle
    step(1);
    leitura = 1'b0;
    check("pushpop_ocup", 32'(ocupacao), 32'd4);
    check("pushpop_desc", 32'(descartado), 32'd0);
    check("pushpop_head", dado_saida, 32'd7);
    check("pushpop_cheia", 32'(cheia), 32'd1);
    step(6);
    botaoEntrada = 1'b1;
    step(12);
    for (int i = 0; i < 4; i++) ler();
    check("drain2_vazia", 32'(vazia), 32'd1);

    // Sign bit extension
    press(18'h20000, 1'b1);
`ifdef FILA_ENTRADA_SINAL_EN
    check("sign_ext", dado_saida, 32'hFFFE0000);
`else
    check("zero_ext", dado_saida, 32'h00020000);
`endif
    ler();

    // Reset during FILTRA_APERTO with 2 entries stored
    press(18'd11, 1'b1);
    press(18'd12, 1'b1);
    check("pre_rst_ocup", 32'(ocupacao), 32'd2);
    dadosExternos = 18'd13;
    botaoEntrada  = 1'b0;
    step(4);
    reset        = 1'b1;
    botaoEntrada = 1'b1;
    step(1);
    reset = 1'b0;
    exp_q.delete();
    check("midrst_ocup", 32'(ocupacao), 32'd0);
    check("midrst_vazia", 32'(vazia), 32'd1);
    step(10);
    check("midrst_nopush", 32'(ocupacao), 32'd0);
    check("midrst_led", 32'(ledentrada), 32'd0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
